video_pattern_gen: RTL and testbench

//  Source-side video timing and test-pattern generator; drives i_vsync/i_hsync/i_de/i_*_data of line_buf_ctrl_top.

---
 rtl/video_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_video_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and RGB test-pattern source (vsync/hsync/de plus four patterns).
// Optional MOVING_PATTERN_EN adds a per-frame counter that scrolls patterns 1/2.
module video_pattern_gen #(
  parameter int VSW  = 1,
  parameter int VBP  = 1,
  parameter int VACT = 4,
  parameter int VFP  = 1,
  parameter int HSW  = 1,
  parameter int HBP  = 2,
  parameter int HACT = 10,
  parameter int HFP  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic [1:0] i_pat_sel,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data,
  output logic       o_frame_start,
  output logic       o_busy
);

  localparam logic [7:0] H_SYNC_END = 8'(HSW);
  localparam logic [7:0] H_ACT_BEG  = 8'(HSW + HBP);
  localparam logic [7:0] H_ACT_END  = 8'(HSW + HBP + HACT);
  localparam logic [7:0] H_LAST     = 8'(HSW + HBP + HACT + HFP - 1);
  localparam logic [7:0] V_SYNC_END = 8'(VSW);
  localparam logic [7:0] V_ACT_BEG  = 8'(VSW + VBP);
  localparam logic [7:0] V_ACT_END  = 8'(VSW + VBP + VACT);
  localparam logic [7:0] V_LAST     = 8'(VSW + VBP + VACT + VFP - 1);
  localparam logic [5:0] X_OFS      = 6'(HSW + HBP);
  localparam logic [5:0] Y_OFS      = 6'(VSW + VBP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic       en_q;
  logic [7:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic [1:0] pat, pat_nxt;
  logic       run, de_c;
  logic [5:0] x, y, xm;
  logic [9:0] r_c, g_c, b_c;

  // Frame boundaries are the only place the run request and pattern are honoured,
  // so a dropped i_en always lets the current frame finish.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    pat_nxt   = pat;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (en_q) begin
          state_nxt = RUN;
          pat_nxt   = i_pat_sel;
        end
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt = '0;
            if (en_q) pat_nxt = i_pat_sel;
            else      state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 8'd1;
          end
        end else begin
          h_nxt = h_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      en_q  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      pat   <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= i_en;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      pat   <= pat_nxt;
    end
  end

`ifdef MOVING_PATTERN_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                              frame_cnt <= '0;
    else if (state == IDLE)                                 frame_cnt <= '0;
    else if (h_cnt == H_LAST && v_cnt == V_LAST && en_q)    frame_cnt <= frame_cnt + 6'd1;
  end
`endif

  assign run  = (state == RUN);
  assign de_c = run && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END)
                    && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  // Coordinates wrap mod 64; they are only meaningful inside the active window.
  assign x    = h_cnt[5:0] - X_OFS;
  assign y    = v_cnt[5:0] - Y_OFS;
`ifdef MOVING_PATTERN_EN
  assign xm   = x + frame_cnt;
`else
  assign xm   = x;
`endif

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (de_c) begin
      case (pat)
        2'd0: begin
          r_c = 10'h200;
          g_c = 10'h200;
          b_c = 10'h200;
        end
        2'd1: begin
          r_c = {xm, 4'b0};
          g_c = {xm, 4'b0};
          b_c = {xm, 4'b0};
        end
        2'd2: begin
          r_c = {10{xm[2]}};
          g_c = {10{xm[1]}};
          b_c = {10{xm[0]}};
        end
        default: begin
          r_c = {4'b0, x};
          g_c = {4'b0, y};
`ifdef MOVING_PATTERN_EN
          b_c = {4'b0, frame_cnt};
`else
          b_c = 10'h155;
`endif
        end
      endcase
    end
  end

  // NOTE: only control/datapath flops exist here, so all of them take the async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_vsync       <= 1'b0;
      o_hsync       <= 1'b0;
      o_de          <= 1'b0;
      o_r_data      <= '0;
      o_g_data      <= '0;
      o_b_data      <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_vsync       <= run && (v_cnt < V_SYNC_END);
      o_hsync       <= run && (h_cnt < H_SYNC_END);
      o_de          <= de_c;
      o_r_data      <= r_c;
      o_g_data      <= g_c;
      o_b_data      <= b_c;
      o_frame_start <= run && (h_cnt == 8'd0) && (v_cnt == 8'd0);
      o_busy        <= run;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: timing table, pixel scoreboard,
// enable-drop, pattern change at frame boundary and asynchronous reset corners.
module tb_video_pattern_gen;

  localparam int HTOT   = 15;
  localparam int FTOT   = 105;
  localparam int NFRAME = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_en;
  logic [1:0] i_pat_sel;
  logic       o_vsync, o_hsync, o_de, o_frame_start, o_busy;
  logic [9:0] o_r_data, o_g_data, o_b_data;

  video_pattern_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_en         (i_en),
    .i_pat_sel    (i_pat_sel),
    .o_vsync      (o_vsync),
    .o_hsync      (o_hsync),
    .o_de         (o_de),
    .o_r_data     (o_r_data),
    .o_g_data     (o_g_data),
    .o_b_data     (o_b_data),
    .o_frame_start(o_frame_start),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs, hs, de, fs, busy;
    logic [9:0] r, g, b;
  } sample_t;

  typedef struct {
    int         cyc;
    logic       vs, hs, de, fs, busy;
    logic [1:0] pat;
    int         x, y;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [29:0] exp_q[$];
  bit          sb_active = 1'b0;
  sample_t     cap[NFRAME*FTOT];
  vec_t        vecs[$];
  logic [1:0]  pats[NFRAME] = '{2'd3, 2'd1, 2'd2, 2'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference pixel {R,G,B} for pattern p at active coordinate (x,y) in frame f.
  function automatic logic [29:0] pix(input logic [1:0] p, input int x, input int y, input int f);
    logic [5:0] xs, ys, fc, xm;
    logic [9:0] r, g, b;
    xs = 6'(x);
    ys = 6'(y);
`ifdef MOVING_PATTERN_EN
    fc = 6'(f);
`else
    fc = 6'd0;
`endif
    xm = xs + fc;
    case (p)
      2'd0:    begin r = 10'h200; g = 10'h200; b = 10'h200; end
      2'd1:    begin r = {xm, 4'b0}; g = r; b = r; end
      2'd2:    begin r = {10{xm[2]}}; g = {10{xm[1]}}; b = {10{xm[0]}}; end
      default: begin
        r = {4'b0, xs};
        g = {4'b0, ys};
`ifdef MOVING_PATTERN_EN
        b = {4'b0, fc};
`else
        b = 10'h155;
`endif
      end
    endcase
    return {r, g, b};
  endfunction

  function automatic sample_t snap();
    return '{o_vsync, o_hsync, o_de, o_frame_start, o_busy, o_r_data, o_g_data, o_b_data};
  endfunction

  task automatic push_frame(input logic [1:0] p, input int f);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 10; xx++)
        exp_q.push_back(pix(p, xx, yy, f));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, 32'(o_vsync), 0);
    check({tag, "_hsync"}, 32'(o_hsync), 0);
    check({tag, "_de"},    32'(o_de), 0);
    check({tag, "_rgb"},   32'({o_r_data, o_g_data, o_b_data}), 0);
    check({tag, "_fs"},    32'(o_frame_start), 0);
    check({tag, "_busy"},  32'(o_busy), 0);
  endtask

  // Scoreboard consumer: one expected pixel per DUT data-enable cycle.
  always @(negedge clk) begin
    if (sb_active && o_de) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        check("sb_pixel", 32'({o_r_data, o_g_data, o_b_data}), 32'(e));
      end
    end
  end

  initial begin
    int n, cnt, hs_cnt, vs_cnt;

    // cyc, vs, hs, de, fs, busy, pat, x, y  (cyc is global: frame*105 + frame cycle)
    vecs.push_back('{0,   1, 1, 0, 1, 1, 2'd3, 0, 0});
    vecs.push_back('{1,   1, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{14,  1, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{15,  0, 1, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{32,  0, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{33,  0, 0, 1, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{42,  0, 0, 1, 0, 1, 2'd3, 9, 0});
    vecs.push_back('{43,  0, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{48,  0, 0, 1, 0, 1, 2'd3, 0, 1});
    vecs.push_back('{87,  0, 0, 1, 0, 1, 2'd3, 9, 3});
    vecs.push_back('{88,  0, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{90,  0, 1, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{104, 0, 0, 0, 0, 1, 2'd3, 0, 0});
    vecs.push_back('{105, 1, 1, 0, 1, 1, 2'd1, 0, 0});
    vecs.push_back('{138, 0, 0, 1, 0, 1, 2'd1, 0, 0});
    vecs.push_back('{143, 0, 0, 1, 0, 1, 2'd1, 5, 0});
    vecs.push_back('{243, 0, 0, 1, 0, 1, 2'd2, 0, 0});
    vecs.push_back('{244, 0, 0, 1, 0, 1, 2'd2, 1, 0});
    vecs.push_back('{246, 0, 0, 1, 0, 1, 2'd2, 3, 0});
    vecs.push_back('{250, 0, 0, 1, 0, 1, 2'd2, 7, 0});
    vecs.push_back('{251, 0, 0, 1, 0, 1, 2'd2, 8, 0});
    vecs.push_back('{347, 0, 0, 0, 0, 1, 2'd0, 0, 0});
    vecs.push_back('{348, 0, 0, 1, 0, 1, 2'd0, 0, 0});
    vecs.push_back('{419, 0, 0, 0, 0, 1, 2'd0, 0, 0});

    rstn      = 1'b0;
    i_en      = 1'b0;
    i_pat_sel = 2'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Start latency: enable sampled at edge k, first sync/frame_start after edge k+2.
    i_en      = 1'b1;
    i_pat_sel = 2'd3;
    @(negedge clk);
    check("lat_k_fs", 32'(o_frame_start), 0);
    check("lat_k_busy", 32'(o_busy), 0);
    @(negedge clk);
    check("lat_k1_fs", 32'(o_frame_start), 0);
    check("lat_k1_vs", 32'(o_vsync), 0);
    @(negedge clk);
    check("lat_k2_fs", 32'(o_frame_start), 1);

    // Four back-to-back frames; pattern select changes mid-frame, enable drops in the last.
    sb_active = 1'b1;
    for (int g = 0; g < NFRAME * FTOT; g++) begin
      if (g > 0) @(negedge clk);
      if (g % FTOT == 0) push_frame(pats[g / FTOT], g / FTOT);
      cap[g] = snap();
      if (g % FTOT == 50) begin
        if (g / FTOT < NFRAME - 1) i_pat_sel = pats[g / FTOT + 1];
        else                       i_en = 1'b0;
      end
    end
    @(negedge clk);
    check("end_busy_fall", 32'(o_busy), 0);
    check("end_no_vsync", 32'(o_vsync), 0);
    check("end_no_fs", 32'(o_frame_start), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      sample_t     s;
      logic [29:0] e;
      s = cap[vecs[i].cyc];
      e = vecs[i].de ? pix(vecs[i].pat, vecs[i].x, vecs[i].y, vecs[i].cyc / FTOT) : 30'd0;
      check($sformatf("vec%0d_c%0d_vs", i, vecs[i].cyc), 32'(s.vs), 32'(vecs[i].vs));
      check($sformatf("vec%0d_c%0d_hs", i, vecs[i].cyc), 32'(s.hs), 32'(vecs[i].hs));
      check($sformatf("vec%0d_c%0d_de", i, vecs[i].cyc), 32'(s.de), 32'(vecs[i].de));
      check($sformatf("vec%0d_c%0d_fs", i, vecs[i].cyc), 32'(s.fs), 32'(vecs[i].fs));
      check($sformatf("vec%0d_c%0d_busy", i, vecs[i].cyc), 32'(s.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_c%0d_rgb", i, vecs[i].cyc), 32'({s.r, s.g, s.b}), 32'(e));
    end

    for (int f = 0; f < NFRAME; f++) begin
      cnt    = 0;
      hs_cnt = 0;
      vs_cnt = 0;
      for (int c = 0; c < FTOT; c++) begin
        cnt    += int'(cap[f*FTOT + c].de);
        hs_cnt += int'(cap[f*FTOT + c].hs);
        vs_cnt += int'(cap[f*FTOT + c].vs);
      end
      check($sformatf("frame%0d_de_count", f), 32'(cnt), 32'd40);
      check($sformatf("frame%0d_hs_count", f), 32'(hs_cnt), 32'(FTOT / HTOT));
      check($sformatf("frame%0d_vs_count", f), 32'(vs_cnt), 32'(HTOT));
    end

    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (o_vsync || o_busy || o_frame_start) cnt++;
    end
    check("idle_quiet", 32'(cnt), 0);
    check("sb_drain", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a line, then restart from (0,0).
    sb_active = 1'b0;
    i_pat_sel = 2'd3;
    i_en      = 1'b1;
    n = 0;
    while (!o_frame_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("run2_latency", 32'(n), 32'd3);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(o_busy), 1);
    #1 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_k_fs", 32'(o_frame_start), 0);
    @(negedge clk);
    check("rst_k1_fs", 32'(o_frame_start), 0);
    @(negedge clk);
    check("restart_fs", 32'(o_frame_start), 1);
    check("restart_vs", 32'(o_vsync), 1);
    check("restart_hs", 32'(o_hsync), 1);
    repeat (HTOT) @(negedge clk);
    check("restart_line1_vs", 32'(o_vsync), 0);
    check("restart_line1_hs", 32'(o_hsync), 1);
    i_en = 1'b0;
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("final_busy_fall", 32'(o_busy), 0);
    check("final_drain_len", 32'(n), 32'(FTOT - HTOT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
